// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: requests one 16-bit word at PC, presents it to
// decode, and handles branch redirects (including ones that race a pending read) and HLT.
module fetch_controller #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {S_REQ, S_OUT, S_HALT} state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] tgt, tgt_nx;
  logic [15:0] iout, iout_nx;
  logic [15:0] ipc, ipc_nx;
  logic [15:0] ret, ret_nx;
  logic        squash, squash_nx;
  logic [15:0] rtgt;

  // Instructions are halfword aligned; the target LSB is never honoured.
  assign rtgt = redirect_pc & 16'hFFFE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      tgt    <= 16'h0000;
      iout   <= 16'h0000;
      ipc    <= 16'h0000;
      ret    <= 16'h0000;
      squash <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      tgt    <= tgt_nx;
      iout   <= iout_nx;
      ipc    <= ipc_nx;
      ret    <= ret_nx;
      squash <= squash_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    tgt_nx    = tgt;
    iout_nx   = iout;
    ipc_nx    = ipc;
    ret_nx    = ret;
    squash_nx = squash;
    case (state)
      S_REQ: begin
        if (redirect) begin
          if (mem_ready) begin
            pc_nx     = rtgt;
            squash_nx = 1'b0;
          end else begin
            // The in-flight read must still complete at the old address.
            squash_nx = 1'b1;
            tgt_nx    = rtgt;
          end
        end else if (mem_ready) begin
          if (squash) begin
            pc_nx     = tgt;
            squash_nx = 1'b0;
          end else begin
            iout_nx  = mem_data;
            ipc_nx   = pc;
            pc_nx    = pc + 16'd2;
            state_nx = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (instr_ready && ret != 16'hFFFF) ret_nx = ret + 16'd1;
        if (redirect) begin
          pc_nx    = rtgt;
          state_nx = S_REQ;
        end else if (instr_ready) begin
          state_nx = (iout[15:12] == 4'hF) ? S_HALT : S_REQ;
        end
      end
      S_HALT: ;
      default: state_nx = S_REQ;
    endcase
  end

  assign mem_req     = !rst && (state == S_REQ);
  assign instr_valid = !rst && (state == S_OUT);
  assign mem_addr    = pc;
  assign instr_out   = iout;
  assign instr_pc    = ipc;
  assign halted      = (state == S_HALT);
  assign retired     = ret;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random traffic, all
// compared every cycle against an event-level reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic [15:0] retired;

  fetch_controller #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: "holding" means a word is waiting for decode,
  // "stopped" means HLT retired, "pending_redirect" means a redirect must
  // wait for the outstanding read to come back before taking effect.
  bit          holding, stopped, pending_redirect;
  int          m_pc, m_target, m_word, m_word_pc, m_count;

  task automatic model_edge();
    if (rst) begin
      holding = 0; stopped = 0; pending_redirect = 0;
      m_pc = 0; m_word = 0; m_word_pc = 0; m_count = 0;
    end else if (stopped) begin
    end else if (holding) begin
      if (instr_ready) m_count = (m_count < 65535) ? m_count + 1 : 65535;
      if (redirect) begin
        m_pc = redirect_pc - (redirect_pc % 2);
        holding = 0;
      end else if (instr_ready) begin
        holding = 0;
        stopped = (m_word / 4096 == 15);
      end
    end else begin
      if (redirect && mem_ready) begin
        m_pc = redirect_pc - (redirect_pc % 2);
        pending_redirect = 0;
      end else if (redirect) begin
        pending_redirect = 1;
        m_target = redirect_pc - (redirect_pc % 2);
      end else if (mem_ready && pending_redirect) begin
        m_pc = m_target;
        pending_redirect = 0;
      end else if (mem_ready) begin
        m_word = mem_data;
        m_word_pc = m_pc;
        m_pc = (m_pc + 2) % 65536;
        holding = 1;
      end
    end
  endtask

  task automatic compare();
    check("mem_req",     {31'd0, mem_req},     {31'd0, !rst && !holding && !stopped});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, !rst && holding});
    check("mem_addr",    {16'd0, mem_addr},    m_pc);
    check("instr_out",   {16'd0, instr_out},   m_word);
    check("instr_pc",    {16'd0, instr_pc},    m_word_pc);
    check("halted",      {31'd0, halted},      {31'd0, stopped});
    check("retired",     {16'd0, retired},     m_count);
  endtask

  task automatic drive(input bit r, input bit mr, input logic [15:0] md,
                       input bit ir, input bit rd, input logic [15:0] rpc);
    rst = r; mem_ready = mr; mem_data = md;
    instr_ready = ir; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic cyc();
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    holding = 0; stopped = 0; pending_redirect = 0;
    m_pc = 0; m_target = 0; m_word = 0; m_word_pc = 0; m_count = 0;
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); model_edge(); #1;

    // Reset, then a fetch with three wait cycles.
    drive(1, 0, 0, 0, 0, 0);
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_valid", {31'd0, instr_valid}, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check("first_req", {31'd0, mem_req}, 1);
    check("first_addr", {16'd0, mem_addr}, 32'h0000);
    repeat (3) cyc();
    drive(0, 1, 16'h1234, 1, 0, 0); cyc();
    drive(0, 0, 0, 1, 0, 0);
    check("out_1234", {16'd0, instr_out}, 32'h1234);
    check("pc_1234", {16'd0, instr_pc}, 32'h0000);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check("next_addr", {16'd0, mem_addr}, 32'h0002);
    check("ret_1", {16'd0, retired}, 1);

    // Decode stalls for five cycles.
    drive(0, 1, 16'h5678, 0, 0, 0); cyc();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("stall_valid", {31'd0, instr_valid}, 1);
      check("stall_out", {16'd0, instr_out}, 32'h5678);
      check("stall_req", {31'd0, mem_req}, 0);
      check("stall_ret", {16'd0, retired}, 1);
      cyc();
    end
    drive(0, 0, 0, 1, 0, 0); cyc();

    // Redirect racing an outstanding read.
    drive(0, 0, 0, 0, 1, 16'h0101); cyc();
    drive(0, 1, 16'hAAAA, 0, 0, 0);
    check("squash_hold", {16'd0, mem_addr}, 32'h0004);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check("squash_novalid", {31'd0, instr_valid}, 0);
    check("squash_addr", {16'd0, mem_addr}, 32'h0100);
    cyc();

    // PC wrap at the top of memory.
    drive(0, 1, 0, 0, 1, 16'hFFFE); cyc();
    drive(0, 1, 16'h1111, 0, 0, 0);
    check("top_addr", {16'd0, mem_addr}, 32'hFFFE);
    cyc();
    drive(0, 0, 0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0);
    check("wrap_addr", {16'd0, mem_addr}, 32'h0000);
    cyc();

    // HLT with a simultaneous redirect does not halt.
    drive(0, 1, 16'hF000, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 1, 16'h0040); cyc();
    drive(0, 0, 0, 0, 0, 0);
    check("hlt_redir_halt", {31'd0, halted}, 0);
    check("hlt_redir_addr", {16'd0, mem_addr}, 32'h0040);
    cyc();

    // HLT freezes everything until reset.
    drive(0, 1, 16'hF123, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 0, 0); cyc();
    for (int i = 0; i < 100; i++) begin
      drive(0, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      check("halt_flag", {31'd0, halted}, 1);
      check("halt_req", {31'd0, mem_req}, 0);
      cyc();
    end
    drive(1, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0);
    check("post_halt_addr", {16'd0, mem_addr}, 32'h0000);
    check("post_halt_ret", {16'd0, retired}, 0);
    check("post_halt_req", {31'd0, mem_req}, 1);
    cyc();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 7) != 0) d[15:12] = d[15:12] & 4'h7;
      drive($urandom_range(0, 47) == 0, $urandom_range(0, 2) == 0, d,
            $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0, 16'($urandom));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port mem_req  output  1  instruction-memory read request.
REQ-005 The block SHALL have port mem_addr  output  16  read address, equal to the current PC.
REQ-006 The block SHALL have port mem_ready  input  1  memory returns mem_data this cycle.
REQ-007 The block SHALL have port mem_data  input  16  instruction word from memory.
REQ-008 The block SHALL have port instr_valid  output  1  instr_out/instr_pc are valid for decode.
REQ-009 The block SHALL have port instr_ready  input  1  decode accepts the instruction this cycle.
REQ-010 The block SHALL have port instr_out  output  16  fetched instruction.
REQ-011 The block SHALL have port instr_pc  output  16  address instr_out was fetched from.
REQ-012 The block SHALL have port redirect  input  1  branch taken (B/BR resolved); load redirect_pc.
REQ-013 The block SHALL have port redirect_pc  input  16  branch target.
REQ-014 The block SHALL have port halted  output  1  HLT (opcode 4'hF) has been accepted.
REQ-015 The block SHALL have port retired  output  16  count of accepted instructions.

Function
REQ-016 The block SHALL implement three states: REQ, OUT and HALT.
REQ-017 In REQ the block SHALL drive mem_req=1, mem_addr=pc and instr_valid=0, and SHALL hold mem_addr stable until mem_ready=1.
REQ-018 When mem_ready=1 in REQ with no squash pending, the block SHALL on that edge set instr_out=mem_data, instr_pc=pc, pc=pc+2, and state=OUT.
REQ-019 PC arithmetic SHALL be 16-bit modulo, so 16'hFFFE+2 wraps to 16'h0000.
REQ-020 Loading redirect_pc SHALL force bit 0 to 0.
REQ-021 In OUT the block SHALL drive instr_valid=1 and mem_req=0, and SHALL hold instr_out/instr_pc stable until instr_ready=1.
REQ-022 On instr_ready=1 in OUT, retired SHALL increment (saturating at 16'hFFFF), and the next state SHALL be HALT if instr_out[15:12]==4'hF, else REQ.
REQ-023 On redirect=1 in OUT, the block SHALL set pc=redirect_pc and state=REQ; redirect SHALL win over an HLT accepted in the same cycle, though retired still increments if instr_ready=1.
REQ-024 On redirect=1 in REQ with mem_ready=0, the block SHALL set a squash flag and store the target, and mem_addr SHALL stay unchanged.
REQ-025 On mem_ready=1 with squash set, the block SHALL discard mem_data, set pc=stored target, clear squash, and remain in REQ.
REQ-026 On redirect=1 and mem_ready=1 in the same REQ cycle, the block SHALL discard mem_data, set pc=redirect_pc, and remain in REQ.
REQ-027 A later redirect while squash is pending SHALL overwrite the stored target.
REQ-028 In HALT the block SHALL hold mem_req=0, instr_valid=0 and halted=1, and pc and retired SHALL be frozen; redirect, mem_ready and instr_ready SHALL be ignored.
REQ-029 Latency SHALL be: mem_ready edge to instr_valid=1 is 1 cycle; instr_ready edge to mem_req=1 is 1 cycle.
REQ-030 mem_data SHALL NOT be sampled outside REQ.

Reset
REQ-031 With rst=1 at a rising edge, the block SHALL set pc=RESET_PC, state=REQ, squash=0, retired=0, instr_out=0, instr_pc=0 and halted=0.
REQ-032 During any cycle with rst=1, the block SHALL drive mem_req=0 and instr_valid=0.
REQ-033 Reset SHALL override every state, including HALT and a pending squash, and the first cycle after rst falls SHALL show mem_req=1, mem_addr=RESET_PC.

Verification
REQ-034 The bench SHALL cover: reset, memory returns 16'h1234 after 3 wait cycles, instr_ready held 1 -> mem_addr=0x0000, instr_out=0x1234, instr_pc=0x0000, next mem_addr=0x0002, retired=1.
REQ-035 The bench SHALL cover: instr_ready=0 for 5 cycles in OUT -> instr_valid stays 1, instr_out stable, mem_req=0, retired unchanged.
REQ-036 The bench SHALL cover: redirect=1, redirect_pc=0x0101 during a REQ wait, then mem_ready with data 0xAAAA -> 0xAAAA is never presented and the next request is to mem_addr=0x0100.
REQ-037 The bench SHALL cover: an accepted instruction 0xF123 -> halted=1 and mem_req=0 for 100 cycles with random redirect/mem_ready; then rst -> mem_addr=RESET_PC, retired=0.
REQ-038 The bench SHALL cover: pc preloaded near the top via redirect_pc=0xFFFE, fetch accepted -> next mem_addr=0x0000.
REQ-039 The bench SHALL cover: instruction 0xF000 accepted with redirect=1, redirect_pc=0x0040 in the same cycle -> no halt, next mem_addr=0x0040.
